// File: rtl/circuit3_vector_sequencer.sv
// Self-test sequencer for the 3-input OR test circuit: walks all 8 input vectors,
// samples y after a settle delay and reports pass/fail, responses and first failing vector.
module circuit3_vector_sequencer #(
  parameter logic [7:0]  EXP_TRUTH     = 8'hFE,
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter int unsigned CNT_W         = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       abort,
  input  logic       dut_y,
  output logic       dut_a,
  output logic       dut_b,
  output logic       dut_c,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] fail_count,
  output logic [2:0] first_fail_vec,
  output logic [7:0] resp_vec
);

  localparam int unsigned VEC_W  = 3;
  localparam int unsigned FAIL_W = 4;
  localparam logic [CNT_W-1:0] SETTLE_LOAD =
    (SETTLE_CYCLES == 0) ? '0 : CNT_W'(SETTLE_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_APPLY,
    S_SETTLE,
    S_SAMPLE,
    S_DONE
  } state_t;

  state_t             state;
  logic [VEC_W-1:0]   vec_q;
  logic [VEC_W-1:0]   abc_q;
  logic [CNT_W-1:0]   settle_cnt;
  logic               mismatch_c;
  logic [FAIL_W-1:0]  fail_next_c;

  assign {dut_a, dut_b, dut_c} = abc_q;

  // Outcome of the vector currently being sampled
  always_comb begin
    mismatch_c  = (dut_y != EXP_TRUTH[vec_q]);
    fail_next_c = fail_count + FAIL_W'(mismatch_c);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= S_IDLE;
      vec_q          <= '0;
      abc_q          <= '0;
      settle_cnt     <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      pass           <= 1'b0;
      fail_count     <= '0;
      first_fail_vec <= '0;
      resp_vec       <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (abort) begin
            state <= S_IDLE;
            done  <= 1'b0;
            pass  <= 1'b0;
          end else if (start) begin
            state          <= S_APPLY;
            vec_q          <= '0;
            abc_q          <= '0;
            busy           <= 1'b1;
            done           <= 1'b0;
            pass           <= 1'b0;
            fail_count     <= '0;
            first_fail_vec <= '0;
            resp_vec       <= '0;
          end
        end

        S_APPLY: begin
          if (abort) begin
            state <= S_IDLE;
            abc_q <= '0;
            busy  <= 1'b0;
          end else if (SETTLE_CYCLES == 0) begin
            state <= S_SAMPLE;
          end else begin
            settle_cnt <= SETTLE_LOAD;
            state      <= S_SETTLE;
          end
        end

        S_SETTLE: begin
          if (abort) begin
            state <= S_IDLE;
            abc_q <= '0;
            busy  <= 1'b0;
          end else if (settle_cnt == '0) begin
            state <= S_SAMPLE;
          end else begin
            settle_cnt <= settle_cnt - CNT_W'(1);
          end
        end

        S_SAMPLE: begin
          if (abort) begin
            // aborted vector's sample is discarded
            state <= S_IDLE;
            abc_q <= '0;
            busy  <= 1'b0;
          end else begin
            resp_vec[vec_q] <= dut_y;
            fail_count      <= fail_next_c;
            if (mismatch_c && (fail_count == '0)) begin
              first_fail_vec <= vec_q;
            end
            if (vec_q == VEC_W'(7)) begin
              state <= S_DONE;
              abc_q <= '0;
              busy  <= 1'b0;
              done  <= 1'b1;
              pass  <= (fail_next_c == '0);
            end else begin
              state <= S_APPLY;
              vec_q <= vec_q + VEC_W'(1);
              abc_q <= vec_q + VEC_W'(1);
            end
          end
        end

        default: begin
          state <= S_IDLE;
          abc_q <= '0;
          busy  <= 1'b0;
          done  <= 1'b0;
          pass  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_circuit3_vector_sequencer.sv
// Bench for circuit3_vector_sequencer: two instances (settle 2 and settle 0) driven by a
// table-based fault model, checked cycle by cycle against a schedule-level reference.
module tb_circuit3_vector_sequencer;

  localparam logic [7:0] EXP_T = 8'hFE;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic abort = 1'b0;

  logic [7:0] tbl2 = 8'hFE;
  logic [7:0] tbl0 = 8'hFE;

  logic a2, b2, c2, y2, busy2, done2, pass2;
  logic [3:0] fc2;
  logic [2:0] ff2;
  logic [7:0] resp2;
  logic a0, b0, c0, y0, busy0, done0, pass0;
  logic [3:0] fc0;
  logic [2:0] ff0;
  logic [7:0] resp0;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  // Circuit under test modelled as a truth table (good circuit = 8'hFE)
  assign y2 = tbl2[{a2, b2, c2}];
  assign y0 = tbl0[{a0, b0, c0}];

  circuit3_vector_sequencer #(.EXP_TRUTH(8'hFE), .SETTLE_CYCLES(2), .CNT_W(4)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .dut_y(y2),
    .dut_a(a2), .dut_b(b2), .dut_c(c2), .busy(busy2), .done(done2), .pass(pass2),
    .fail_count(fc2), .first_fail_vec(ff2), .resp_vec(resp2)
  );

  circuit3_vector_sequencer #(.EXP_TRUTH(8'hFE), .SETTLE_CYCLES(0), .CNT_W(4)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .dut_y(y0),
    .dut_a(a0), .dut_b(b0), .dut_c(c0), .busy(busy0), .done(done0), .pass(pass0),
    .fail_count(fc0), .first_fail_vec(ff0), .resp_vec(resp0)
  );

  function automatic logic [31:0] obs(input bit s0);
    if (s0) return {11'd0, busy0, done0, pass0, fc0, ff0, resp0, a0, b0, c0};
    return {11'd0, busy2, done2, pass2, fc2, ff2, resp2, a2, b2, c2};
  endfunction

  function automatic logic [31:0] pack(input logic bsy, input logic dn, input logic ps,
                                       input logic [14:0] r, input logic [2:0] abc);
    return {11'd0, bsy, dn, ps, r, abc};
  endfunction

  // Results after the first n vectors were captured: {fail_count, first_fail_vec, resp_vec}
  function automatic logic [14:0] res(input logic [7:0] tbl, input int n);
    logic [7:0] r;
    int fc;
    int ff;
    r = 8'h00;
    fc = 0;
    ff = -1;
    for (int i = 0; i < n; i++) begin
      r[i] = tbl[i];
      if (tbl[i] != EXP_T[i]) begin
        fc++;
        if (ff < 0) ff = i;
      end
    end
    if (ff < 0) ff = 0;
    return {4'(fc), 3'(ff), r};
  endfunction

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    checks++;
    assert (o === e) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic quiesce();
    start = 1'b0;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    tick();
  endtask

  // One run from a start edge (edge 0); optional abort sampled at edge abort_at
  task automatic run(input bit s0, input logic [7:0] tbl, input int abort_at, input bit hold);
    int per;
    int total;
    logic [14:0] r;
    bit aborted;
    per = s0 ? 2 : 4;
    total = 8 * per;
    aborted = 0;
    if (s0) tbl0 = tbl; else tbl2 = tbl;
    start = 1'b1;
    abort = 1'b0;
    tick();
    chk($sformatf("s%0d_start_e0", s0), obs(s0), pack(1'b1, 1'b0, 1'b0, 15'd0, 3'd0));
    for (int e = 1; e <= total; e++) begin
      start = hold;
      abort = (e == abort_at);
      tick();
      if (abort_at != 0 && e == abort_at) begin
        r = res(tbl, (e - 1) / per);
        chk($sformatf("s%0d_abort_e%0d", s0, e), obs(s0), pack(1'b0, 1'b0, 1'b0, r, 3'd0));
        abort = 1'b0;
        aborted = 1;
        break;
      end else if (e < total) begin
        r = res(tbl, e / per);
        chk($sformatf("s%0d_run_e%0d", s0, e), obs(s0), pack(1'b1, 1'b0, 1'b0, r, 3'(e / per)));
      end else begin
        r = res(tbl, 8);
        chk($sformatf("s%0d_done_e%0d", s0, e), obs(s0),
            pack(1'b0, 1'b1, (r[14:11] == 4'd0), r, 3'd0));
      end
    end
    start = 1'b0;
    if (!aborted) begin
      tick();
      r = res(tbl, 8);
      chk($sformatf("s%0d_done_hold", s0), obs(s0), pack(1'b0, 1'b1, (r[14:11] == 4'd0), r, 3'd0));
    end
  endtask

  task automatic abort_in_done(input bit s0, input logic [7:0] tbl);
    logic [14:0] r;
    r = res(tbl, 8);
    abort = 1'b1;
    tick();
    chk("abort_in_done", obs(s0), pack(1'b0, 1'b0, 1'b0, r, 3'd0));
    start = 1'b1;
    tick();
    chk("abort_beats_start", obs(s0), pack(1'b0, 1'b0, 1'b0, r, 3'd0));
    abort = 1'b0;
    start = 1'b0;
  endtask

  initial begin
    logic [7:0] rt;
    bit rs;
    int ab;
    #3;
    chk("reset_s2", obs(1'b0), 32'd0);
    chk("reset_s0", obs(1'b1), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // good circuit, then abort/start interplay in DONE
    run(1'b0, 8'hFE, 0, 1'b0);
    abort_in_done(1'b0, 8'hFE);

    // y stuck at 0
    quiesce();
    run(1'b0, 8'h00, 0, 1'b0);

    // abort mid-run keeps partial results
    quiesce();
    run(1'b0, 8'hFE, 11, 1'b0);

    // async reset mid-settle, then a clean run
    quiesce();
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (6) tick();
    rst_n = 1'b0;
    #2;
    chk("async_reset_s2", obs(1'b0), 32'd0);
    chk("async_reset_s0", obs(1'b1), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    run(1'b0, 8'hFE, 0, 1'b0);

    // start held through a run, then restart from DONE clears counters
    quiesce();
    run(1'b0, 8'h00, 0, 1'b1);
    run(1'b0, 8'hFE, 0, 1'b0);

    // zero settle cycles
    quiesce();
    run(1'b1, 8'hFE, 0, 1'b0);
    quiesce();
    run(1'b1, 8'h5A, 0, 1'b0);

    // randomized fault tables and abort points
    for (int k = 0; k < 10; k++) begin
      quiesce();
      rs = 1'($urandom_range(0, 1));
      rt = 8'($urandom);
      ab = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, rs ? 16 : 32)) : 0;
      run(rs, rt, ab, 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
